// File: rtl/udp_tx_pkt_sched.sv
// Packet scheduler between a shared-clock UDP TX FIFO and the UDP transmit engine.
// Launches full-size frames, flushes short remainders after a write-idle timeout.
module udp_tx_pkt_sched #(
  parameter int PKT_WORDS    = 256,
  parameter int FLUSH_CYCLES = 4096,
  parameter int LVL_W        = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en_in,
  input  logic             wr_full,
  output logic             fifo_rd_en,
  input  logic [31:0]      fifo_rd_data,
  input  logic             fifo_empty,
  output logic             tx_start_en,
  output logic [15:0]      tx_byte_num,
  input  logic             tx_req,
  output logic [31:0]      tx_data,
  input  logic             tx_done,
  output logic             busy,
  output logic [15:0]      pkt_cnt,
  output logic [LVL_W-1:0] level,
  output logic             protocol_err
);

  localparam int IDLE_W = (FLUSH_CYCLES < 1) ? 1 : $clog2(FLUSH_CYCLES + 1);
  localparam bit FLUSH_EN = (FLUSH_CYCLES != 0);
  localparam logic [LVL_W-1:0]  PKT_LEN   = LVL_W'(PKT_WORDS);
  localparam logic [IDLE_W-1:0] IDLE_MAX  = IDLE_W'(FLUSH_CYCLES);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'((FLUSH_CYCLES < 1) ? 0 : FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, START, SEND, WAIT_DONE} state_t;

  state_t            state, state_nxt;
  logic [LVL_W-1:0]  len, len_nxt, rd_cnt;
  logic [IDLE_W-1:0] idle_cnt;
  logic              wr_acc, err_set, start_go;

  assign wr_acc   = wr_en_in & ~wr_full;
  assign tx_data  = fifo_rd_data;
  assign busy     = (state != IDLE);
  assign start_go = (state == IDLE) && (state_nxt == START);

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latches).
    state_nxt  = state;
    len_nxt    = len;
    fifo_rd_en = 1'b0;
    err_set    = 1'b0;
    unique case (state)
      IDLE: begin
        // A full packet wins over a pending flush.
        if (level >= PKT_LEN) begin
          len_nxt   = PKT_LEN;
          state_nxt = START;
        end else if (FLUSH_EN && level != '0 && idle_cnt == IDLE_LAST) begin
          len_nxt   = level;
          state_nxt = START;
        end
      end
      START: state_nxt = SEND;
      SEND: begin
        fifo_rd_en = tx_req && (rd_cnt != len) && !fifo_empty;
        err_set    = (tx_req && fifo_empty && (rd_cnt != len)) || tx_done;
        // An early tx_done abandons the frame; unread words stay queued for the next one.
        if (tx_done)
          state_nxt = IDLE;
        else if (fifo_rd_en && (rd_cnt + LVL_W'(1) == len))
          state_nxt = WAIT_DONE;
      end
      WAIT_DONE: begin
        err_set = tx_req;
        if (tx_done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      len          <= '0;
      rd_cnt       <= '0;
      level        <= '0;
      idle_cnt     <= '0;
      pkt_cnt      <= '0;
      tx_start_en  <= 1'b0;
      tx_byte_num  <= '0;
      protocol_err <= 1'b0;
    end else begin
      state       <= state_nxt;
      tx_start_en <= start_go;
      if (start_go) begin
        len         <= len_nxt;
        tx_byte_num <= 16'({len_nxt, 2'b00});
      end

      if (state == START) begin
        rd_cnt  <= '0;
        pkt_cnt <= pkt_cnt + 16'd1;
      end else if (fifo_rd_en) begin
        rd_cnt <= rd_cnt + LVL_W'(1);
      end

      if (err_set) protocol_err <= 1'b1;

      unique case ({wr_acc, fifo_rd_en})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase

      // Idle timer only runs while parked in IDLE with data waiting and no writes.
      if (wr_acc || level == '0 || state != IDLE)
        idle_cnt <= '0;
      else if (idle_cnt != IDLE_MAX)
        idle_cnt <= idle_cnt + IDLE_W'(1);
    end
  end

endmodule

// File: tb/tb_udp_tx_pkt_sched.sv
// Directed bench for udp_tx_pkt_sched: behavioural FIFO + engine, payload scoreboard.
module tb_udp_tx_pkt_sched;

  localparam int LVL_W = 12;

  logic             clk = 1'b0;
  logic             rst;
  logic             wr_en_in;
  logic             wr_full;
  logic             fifo_rd_en;
  logic [31:0]      fifo_rd_data;
  logic             fifo_empty;
  logic             tx_start_en;
  logic [15:0]      tx_byte_num;
  logic             tx_req;
  logic [31:0]      tx_data;
  logic             tx_done;
  logic             busy;
  logic [15:0]      pkt_cnt;
  logic [LVL_W-1:0] level;
  logic             protocol_err;

  logic [31:0] wr_data;
  logic [31:0] fq[$];
  logic [31:0] exp_q[$];
  int          fifo_cnt;
  logic        rd_q;
  int          checks = 0;
  int          errors = 0;
  int          n_reads = 0;
  int          n_starts = 0;
  int          seq = 0;

  udp_tx_pkt_sched #(.PKT_WORDS(256), .FLUSH_CYCLES(4096), .LVL_W(LVL_W)) dut (
    .clk(clk), .rst(rst), .wr_en_in(wr_en_in), .wr_full(wr_full),
    .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data), .fifo_empty(fifo_empty),
    .tx_start_en(tx_start_en), .tx_byte_num(tx_byte_num), .tx_req(tx_req),
    .tx_data(tx_data), .tx_done(tx_done), .busy(busy), .pkt_cnt(pkt_cnt),
    .level(level), .protocol_err(protocol_err)
  );

  always #5 clk = ~clk;

  // 2048-deep FIFO, read data registered one cycle after fifo_rd_en.
  assign fifo_empty = (fifo_cnt == 0);
  assign wr_full    = (fifo_cnt >= 2048);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      fq.delete();
      fifo_cnt     <= 0;
      fifo_rd_data <= '0;
    end else begin
      if (fifo_rd_en && fq.size() != 0) fifo_rd_data <= fq.pop_front();
      if (wr_en_in && !wr_full) fq.push_back(wr_data);
      fifo_cnt <= fq.size();
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) rd_q <= 1'b0;
    else     rd_q <= fifo_rd_en;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Samples payload and start pulses mid-cycle, then moves to just after the next edge.
  task automatic tick();
    @(negedge clk);
    if (!rst) begin
      if (rd_q) begin
        n_reads++;
        if (exp_q.size() == 0) check("tx_data_unexpected", 32'd1, 32'd0);
        else                   check("tx_data", tx_data, exp_q.pop_front());
      end
      if (tx_start_en) n_starts++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_write(input bit en);
    wr_en_in = en;
    if (en) begin
      wr_data = (32'(seq) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
      if (!wr_full) exp_q.push_back(wr_data);
      seq++;
    end
  endtask

  task automatic write_words(input int n);
    for (int i = 0; i < n; i++) begin
      set_write(1'b1);
      tick();
    end
    set_write(1'b0);
  endtask

  task automatic wait_start(input string tag);
    for (int i = 0; i < 8 && !tx_start_en; i++) tick();
    check(tag, 32'(tx_start_en), 32'd1);
  endtask

  task automatic serve(input int n);
    for (int i = 0; i < n; i++) begin
      tx_req = 1'b1;
      tick();
    end
    tx_req = 1'b0;
    tick();
    check("wait_done_busy", 32'(busy), 32'd1);
    check("wait_done_rd_en", 32'(fifo_rd_en), 32'd0);
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    check("idle_after_done", 32'(busy), 32'd0);
  endtask

  // Producer writes n_wr words back-to-back while a responsive engine serves n_frames frames.
  task automatic run_traffic(input int n_wr, input int n_frames, input int budget,
                             output int both_cnt);
    int req_left = 0;
    int phase = 0;
    int done_frames = 0;
    int cyc = 0;
    bit prev_both = 1'b0;
    logic [LVL_W-1:0] prev_level = '0;
    both_cnt = 0;
    while (done_frames < n_frames && cyc < budget) begin
      if (prev_both) check("level_hold", 32'(level), 32'(prev_level));
      tx_req  = 1'b0;
      tx_done = 1'b0;
      case (phase)
        1: begin tx_req = 1'b1; req_left--; if (req_left == 0) phase = 2; end
        2: phase = 3;
        3: begin tx_done = 1'b1; done_frames++; phase = 0; end
        default: ;
      endcase
      if (tx_start_en) begin
        req_left = int'(tx_byte_num >> 2);
        phase = 1;
      end
      set_write(n_wr > 0);
      if (n_wr > 0) n_wr--;
      #1;
      prev_both  = fifo_rd_en && wr_en_in && !wr_full;
      prev_level = level;
      if (prev_both) both_cnt++;
      tick();
      cyc++;
    end
    tx_req  = 1'b0;
    tx_done = 1'b0;
    set_write(1'b0);
    check("traffic_frames", 32'(done_frames), 32'(n_frames));
  endtask

  initial begin
    int base_reads, base_starts, t, both;
    rst = 1'b1; wr_en_in = 1'b0; wr_data = '0; tx_req = 1'b0; tx_done = 1'b0;
    @(posedge clk); #1;
    check("rst_start_en", 32'(tx_start_en), 32'd0);
    check("rst_byte_num", 32'(tx_byte_num), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_pkt_cnt", 32'(pkt_cnt), 32'd0);
    check("rst_err", 32'(protocol_err), 32'd0);
    check("rst_rd_en", 32'(fifo_rd_en), 32'd0);
    rst = 1'b0;
    tick();

    // Full packet: exact launch latency and a clean 256-word frame.
    base_reads = n_reads; base_starts = n_starts;
    write_words(256);
    check("full_level", 32'(level), 32'd256);
    check("full_start_early", 32'(tx_start_en), 32'd0);
    tick();
    check("full_start", 32'(tx_start_en), 32'd1);
    check("full_bytes", 32'(tx_byte_num), 32'd1024);
    tick();
    check("full_start_pulse", 32'(tx_start_en), 32'd0);
    check("full_pkt_cnt", 32'(pkt_cnt), 32'd1);
    serve(256);
    check("full_level_end", 32'(level), 32'd0);
    check("full_reads", 32'(n_reads - base_reads), 32'd256);
    check("full_starts", 32'(n_starts - base_starts), 32'd1);

    // Short remainder flushed after the write-idle timeout.
    base_reads = n_reads;
    write_words(100);
    t = 0;
    while (!tx_start_en && t < 5000) begin
      tick();
      t++;
    end
    check("flush_latency", 32'(t + 1), 32'd4097);
    check("flush_bytes", 32'(tx_byte_num), 32'd400);
    tick();
    serve(100);
    check("flush_reads", 32'(n_reads - base_reads), 32'd100);
    check("flush_level", 32'(level), 32'd0);
    check("flush_pkt_cnt", 32'(pkt_cnt), 32'd2);

    // Continuous writes during frames: two full frames, no flush, level steady on read+write.
    base_starts = n_starts;
    run_traffic(600, 2, 3000, both);
    check("stream_level", 32'(level), 32'd88);
    check("stream_starts", 32'(n_starts - base_starts), 32'd2);
    check("stream_pkt_cnt", 32'(pkt_cnt), 32'd4);
    check("stream_bytes", 32'(tx_byte_num), 32'd1024);
    check("stream_both_cycles", 32'(both >= 256), 32'd1);
    check("stream_err", 32'(protocol_err), 32'd0);

    // The 88-word leftover drains through a flush frame.
    run_traffic(0, 1, 5000, both);
    check("drain_bytes", 32'(tx_byte_num), 32'd352);
    check("drain_level", 32'(level), 32'd0);
    check("drain_pkt_cnt", 32'(pkt_cnt), 32'd5);
    check("drain_err", 32'(protocol_err), 32'd0);

    // Early tx_done aborts the frame and flags the error.
    write_words(256);
    wait_start("abort_start");
    tick();
    for (int i = 0; i < 10; i++) begin
      tx_req = 1'b1;
      tick();
    end
    tx_req  = 1'b0;
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    check("abort_err", 32'(protocol_err), 32'd1);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_level", 32'(level), 32'd246);
    check("abort_pkt_cnt", 32'(pkt_cnt), 32'd6);

    // Leftover words lead the next frame; reset lands mid-SEND at read 50.
    write_words(10);
    wait_start("resume_start");
    check("resume_bytes", 32'(tx_byte_num), 32'd1024);
    tick();
    check("resume_pkt_cnt", 32'(pkt_cnt), 32'd7);
    for (int i = 0; i < 50; i++) begin
      tx_req = 1'b1;
      tick();
    end
    rst = 1'b1;
    #1;
    check("midrst_rd_en", 32'(fifo_rd_en), 32'd0);
    check("midrst_start_en", 32'(tx_start_en), 32'd0);
    check("midrst_bytes", 32'(tx_byte_num), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_pkt_cnt", 32'(pkt_cnt), 32'd0);
    check("midrst_level", 32'(level), 32'd0);
    check("midrst_err", 32'(protocol_err), 32'd0);
    tx_req = 1'b0;
    exp_q.delete();
    tick();
    rst = 1'b0;
    tick();

    base_reads = n_reads;
    write_words(256);
    wait_start("post_rst_start");
    check("post_rst_bytes", 32'(tx_byte_num), 32'd1024);
    tick();
    check("post_rst_pkt_cnt", 32'(pkt_cnt), 32'd1);
    serve(256);
    check("post_rst_reads", 32'(n_reads - base_reads), 32'd256);
    check("post_rst_level", 32'(level), 32'd0);
    check("post_rst_err", 32'(protocol_err), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
